mvm_sequencer: RTL and testbench
================================

// Module: mvm_sequencer
// PURPOSE
//  Sequencing controller for the matrix-vector multiplier. Accepts one packed
//  M_SIZE x M_SIZE matrix and one packed M_SIZE vector via valid/ready, drives a
//  single shared signed MAC over all M_SIZE*M_SIZE products in row-major order,
//  and returns the packed result vector via valid/ready.
//  Sits between the operand source (packed buses) and the result consumer.
// PARAMETERS
//  D_WIDTH    8                           operand element width, signed two's complement
//  M_SIZE     4                           matrix/vector dimension (>=2)
//  ACC_WIDTH  2*D_WIDTH+$clog2(M_SIZE)    result element width, signed; overflow-free
// PORTS
//  i_clk      in   1                      clock, rising edge
//  i_rst_n    in   1                      asynchronous reset, active low
//  i_valid    in   1                      operand set valid
//  o_ready    out  1                      operand set accepted when i_valid && o_ready
//  i_matrix   in   D_WIDTH*M_SIZE*M_SIZE  element [i][j] at bits (i*M_SIZE+j)*D_WIDTH +: D_WIDTH
//  i_vector   in   D_WIDTH*M_SIZE         element [j] at bits j*D_WIDTH +: D_WIDTH
//  i_abort    in   1                      synchronous abort of a computation in progress
//  o_valid    out  1                      result valid
//  i_ready    in   1                      result consumed when o_valid && i_ready
//  o_result   out  ACC_WIDTH*M_SIZE       row i sum at bits i*ACC_WIDTH +: ACC_WIDTH
//  o_busy     out  1                      high in COMPUTE
// BEHAVIOUR
//  - Reset (i_rst_n low, async): state IDLE, o_ready=1, o_valid=0, o_busy=0,
//    o_result=0, row/col counters=0, accumulators=0, operand registers=0.
//  - States: IDLE -> COMPUTE -> DONE -> IDLE.
//  - IDLE: o_ready=1. On i_valid at a rising edge: register i_matrix/i_vector,
//    clear all accumulators, row=col=0, go COMPUTE. Bus inputs sampled only here.
//  - COMPUTE: o_ready=0, o_busy=1. Each cycle acc[row] += m[row][col]*v[col]
//    (full-precision signed product, sign-extended to ACC_WIDTH). col increments;
//    at col=M_SIZE-1 col wraps to 0 and row increments. On the edge processing
//    row=col=M_SIZE-1 go DONE. Exactly M_SIZE*M_SIZE MAC cycles.
//  - DONE: o_valid=1, o_ready=0, o_result = registered accumulators, stable
//    until handshake. On i_ready: o_valid drops next cycle, go IDLE (o_ready=1
//    the following cycle; no same-cycle accept in DONE).
//  - Latency: o_valid high M_SIZE*M_SIZE cycles after the accepting edge (16 at
//    defaults). Throughput: one operation per M_SIZE*M_SIZE+2 cycles min.
//  - i_valid while not in IDLE: ignored, not queued.
//  - i_abort: in COMPUTE -> IDLE next edge, no o_valid, counters/accs cleared;
//    in IDLE or DONE ignored. Abort has priority over last-MAC transition.
//  - i_ready while o_valid=0: ignored. o_result holds last value after handshake.
//  - Reset mid-COMPUTE or mid-DONE: immediate return to reset values; pending
//    result discarded.
//  - No arithmetic saturation needed: |sum| <= M_SIZE*2^(2*D_WIDTH-2) fits ACC_WIDTH.
// TESTING
//  1. Identity matrix, vector [1,2,3,4] -> o_result rows [1,2,3,4], o_valid 16
//     cycles after accept.
//  2. All elements -128, vector all -128 -> every row 65536 (18'h10000); all
//     127 x -128 -> every row -65024.
//  3. Hold i_ready low 10 cycles after o_valid -> o_result and o_valid stable,
//     o_ready=0; release -> IDLE, next operand accepted 2 cycles later.
//  4. Pulse i_valid with new operands at compute cycle 5 -> ignored; result
//     matches first operands only.
//  5. i_abort at compute cycle 8 -> IDLE next cycle, o_valid never asserts;
//     subsequent op with m[i][j]=i+j, v=[1,1,1,1] -> rows [6,10,14,18].
//  6. Deassert i_rst_n mid-COMPUTE and in DONE -> all outputs to reset values
//     asynchronously; o_ready=1 after release.

Source files
------------

// File: rtl/mvm_sequencer.sv
// Sequencing controller for the matrix-vector multiplier: captures one packed
// matrix/vector pair, runs a single shared signed MAC row-major, returns the sums.
module mvm_sequencer #(
  parameter int D_WIDTH   = 8,
  parameter int M_SIZE    = 4,
  parameter int ACC_WIDTH = 2*D_WIDTH+$clog2(M_SIZE)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [D_WIDTH*M_SIZE*M_SIZE-1:0]     i_matrix,
  input  logic [D_WIDTH*M_SIZE-1:0]            i_vector,
  input  logic                                 i_abort,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [ACC_WIDTH*M_SIZE-1:0]          o_result,
  output logic                                 o_busy
);

  localparam int CW = $clog2(M_SIZE);
  localparam int IW = $clog2(M_SIZE*M_SIZE);
  localparam logic [CW-1:0] LAST = CW'(M_SIZE-1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]                  state_reg;
  logic [CW-1:0]               row_reg;
  logic [CW-1:0]               col_reg;
  logic signed [D_WIDTH-1:0]   mat_reg    [M_SIZE*M_SIZE];
  logic signed [D_WIDTH-1:0]   vec_reg    [M_SIZE];
  logic signed [ACC_WIDTH-1:0] acc_reg    [M_SIZE];
  logic signed [ACC_WIDTH-1:0] acc_next   [M_SIZE];
  logic [ACC_WIDTH-1:0]        result_reg [M_SIZE];

  logic [IW-1:0]               m_idx;
  logic signed [2*D_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic                        last_mac;

  assign m_idx    = IW'(row_reg) * IW'(M_SIZE) + IW'(col_reg);
  assign prod     = mat_reg[m_idx] * vec_reg[col_reg];
  assign prod_ext = ACC_WIDTH'(prod);
  assign last_mac = (row_reg == LAST) && (col_reg == LAST);

  assign o_ready = (state_reg == ST_IDLE);
  assign o_busy  = (state_reg == ST_COMPUTE);
  assign o_valid = (state_reg == ST_DONE);

  // Only the active row's accumulator picks up the product this cycle.
  generate
    for (genvar gi = 0; gi < M_SIZE; gi++) begin : g_row
      assign acc_next[gi] = acc_reg[gi] + ((row_reg == CW'(gi)) ? prod_ext : '0);
      assign o_result[gi*ACC_WIDTH +: ACC_WIDTH] = result_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      for (int k = 0; k < M_SIZE*M_SIZE; k++) mat_reg[k] <= '0;
      for (int k = 0; k < M_SIZE; k++) begin
        vec_reg[k]    <= '0;
        acc_reg[k]    <= '0;
        result_reg[k] <= '0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_valid) begin
            for (int k = 0; k < M_SIZE*M_SIZE; k++)
              mat_reg[k] <= i_matrix[k*D_WIDTH +: D_WIDTH];
            for (int k = 0; k < M_SIZE; k++) begin
              vec_reg[k] <= i_vector[k*D_WIDTH +: D_WIDTH];
              acc_reg[k] <= '0;
            end
            row_reg   <= '0;
            col_reg   <= '0;
            state_reg <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          // Abort wins over the final-MAC transition.
          if (i_abort) begin
            for (int k = 0; k < M_SIZE; k++) acc_reg[k] <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            for (int k = 0; k < M_SIZE; k++) acc_reg[k] <= acc_next[k];
            if (last_mac) begin
              for (int k = 0; k < M_SIZE; k++) result_reg[k] <= acc_next[k];
              row_reg   <= '0;
              col_reg   <= '0;
              state_reg <= ST_DONE;
            end else if (col_reg == LAST) begin
              col_reg <= '0;
              row_reg <= row_reg + CW'(1);
            end else begin
              col_reg <= col_reg + CW'(1);
            end
          end
        end
        ST_DONE: begin
          if (i_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_sequencer.sv
// Self-checking bench for mvm_sequencer: directed table, multi-cycle corner
// sequences and randomized operands against a plain-arithmetic reference model.
module tb_mvm_sequencer;

  localparam int D  = 8;
  localparam int M  = 4;
  localparam int A  = 2*D+$clog2(M);
  localparam int MW = D*M*M;
  localparam int VW = D*M;
  localparam int RW = A*M;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [MW-1:0] i_matrix;
  logic [VW-1:0] i_vector;
  logic          i_abort;
  logic          o_valid;
  logic          i_ready;
  logic [RW-1:0] o_result;
  logic          o_busy;

  always #5 clk = ~clk;

  mvm_sequencer #(.D_WIDTH(D), .M_SIZE(M), .ACC_WIDTH(A)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_matrix (i_matrix),
    .i_vector (i_vector),
    .i_abort  (i_abort),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  typedef struct packed {
    logic [MW-1:0] mat;
    logic [VW-1:0] vec;
    logic [RW-1:0] exp;
  } vec_t;

  vec_t tbl [4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_res(input int r0, input int r1, input int r2, input int r3);
    return {A'(r3), A'(r2), A'(r1), A'(r0)};
  endfunction

  // Reference: each row is the plain integer dot product of matrix row and vector.
  function automatic logic [RW-1:0] model(input logic [MW-1:0] m, input logic [VW-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) begin
      int sum;
      sum = 0;
      for (int j = 0; j < M; j++) begin
        logic signed [D-1:0] a;
        logic signed [D-1:0] b;
        a = m[(i*M+j)*D +: D];
        b = v[j*D +: D];
        sum += int'(a) * int'(b);
      end
      r[i*A +: A] = A'(sum);
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (!o_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "_ready"}, RW'(o_ready), RW'(1));
  endtask

  task automatic start_op(input string name, input logic [MW-1:0] m, input logic [VW-1:0] v);
    wait_ready(name);
    i_matrix = m;
    i_vector = v;
    i_valid  = 1'b1;
    @(negedge clk);
    i_valid  = 1'b0;
    i_matrix = ~m;
    i_vector = ~v;
  endtask

  task automatic run_op(input string name, input logic [MW-1:0] m, input logic [VW-1:0] v,
                        input logic [RW-1:0] e, input int hold, input int inj);
    int cnt;
    bit ok;
    start_op(name, m, v);
    check({name, "_busy"}, RW'({o_busy, o_ready}), RW'(2'b10));
    cnt = 0;
    while (!o_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == inj) begin
        i_valid  = 1'b1;
        i_matrix = rand_mat();
        i_vector = $urandom;
      end else begin
        i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    check({name, "_latency"}, RW'(cnt), RW'(M*M));
    check({name, "_result"}, o_result, e);
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!(o_valid && !o_ready && o_result == e)) ok = 1'b0;
      end
      check({name, "_hold_stable"}, RW'(ok), RW'(1));
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check({name, "_release"}, RW'({o_valid, o_ready}), RW'(2'b01));
    check({name, "_result_kept"}, o_result, e);
  endtask

  initial begin
    logic [MW-1:0] m_tmp;
    logic [MW-1:0] rm;
    logic [VW-1:0] rv;
    int cnt;
    bit ok;

    m_tmp = '0;
    for (int i = 0; i < M; i++) m_tmp[(i*M+i)*D +: D] = 8'd1;
    tbl[0] = '{mat: m_tmp, vec: {8'd4, 8'd3, 8'd2, 8'd1}, exp: pack_res(1, 2, 3, 4)};
    tbl[1] = '{mat: {16{8'h80}}, vec: {4{8'h80}}, exp: pack_res(65536, 65536, 65536, 65536)};
    tbl[2] = '{mat: {16{8'h7f}}, vec: {4{8'h80}}, exp: pack_res(-65024, -65024, -65024, -65024)};
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) m_tmp[(i*M+j)*D +: D] = D'(i+j);
    tbl[3] = '{mat: m_tmp, vec: {4{8'h01}}, exp: pack_res(6, 10, 14, 18)};

    rst_n = 1'b0; i_valid = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    i_matrix = '0; i_vector = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", RW'({o_ready, o_busy, o_valid}), RW'(3'b100));
    check("reset_result", o_result, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 3; k++)
      run_op($sformatf("table%0d", k), tbl[k].mat, tbl[k].vec, tbl[k].exp, (k == 1) ? 10 : 0, -1);

    rm = rand_mat();
    rv = $urandom;
    run_op("ignore_valid", rm, rv, model(rm, rv), 0, 5);

    start_op("abort", rand_mat(), $urandom);
    repeat (7) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_idle", RW'({o_ready, o_busy, o_valid}), RW'(3'b100));
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (o_valid) ok = 1'b0;
    end
    check("abort_no_valid", RW'(ok), RW'(1));
    run_op("after_abort", tbl[3].mat, tbl[3].vec, tbl[3].exp, 0, -1);

    start_op("rst_compute", rand_mat(), $urandom);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_compute_ctrl", RW'({o_ready, o_busy, o_valid}), RW'(3'b100));
    check("rst_compute_result", o_result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_compute_release", RW'({o_ready, o_busy}), RW'(2'b10));

    start_op("rst_done", tbl[0].mat, tbl[0].vec);
    cnt = 0;
    while (!o_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_done_result", o_result, tbl[0].exp);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_ctrl", RW'({o_ready, o_busy, o_valid}), RW'(3'b100));
    check("rst_done_cleared", o_result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done_release", RW'(o_ready), RW'(1));

    for (int k = 0; k < 20; k++) begin
      rm = rand_mat();
      rv = $urandom;
      run_op($sformatf("rand%0d", k), rm, rv, model(rm, rv), int'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
